detector_event_capture: RTL
===========================

Name: detector_event_capture

Overview:
Front-end capture stage of the time tagger, directly upstream of the event serializer/UART path that drives tx_out. Synchronizes the asynchronous detectors inputs and detects rising edges with per-channel dead time. Stamps each hit with a free-running timestamp and queues the resulting events in a show-ahead FIFO. Events are presented downstream over a valid/ready handshake.

Parameters:
NCH, 4, number of detector channels
TS_W, 32, timestamp counter width
DEAD_CYCLES, 4, clk cycles a channel ignores new edges after an accepted hit (0 = disabled)
FIFO_DEPTH, 16, event FIFO entries (power of 2, >= 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
activate  input  1  capture enable; counter runs and hits are accepted only while high
detectors  input  NCH  asynchronous detector pulses, >= 1 clk period wide
ev_valid  output  1  FIFO head holds an event
ev_ready  input  1  downstream accepts the head event
ev_mask  output  NCH  channels hit in the event's cycle
ev_rollover  output  1  event marks a timestamp wrap
ev_timestamp  output  TS_W  timestamp of the event
overflow  output  1  sticky flag: at least one event was dropped
drop_count  output  16  count of dropped events, saturating at 0xFFFF

Behaviour:
- Reset (sampled at clk edge): synchronizers, edge registers, dead counters, ts, FIFO pointers, overflow and drop_count all go to 0. ev_valid=0, ev_mask=0, ev_rollover=0, ev_timestamp=0. Reset has priority over every other action; reset mid-operation discards all queued events.
- Synchronizer: per channel s1<=det, s2<=s1, s3<=s2. A raw hit on channel i is s2 & ~s3.
- Accepted hit on channel i requires: raw hit, activate=1 and dead_cnt[i]==0. On acceptance, dead_cnt[i]<=DEAD_CYCLES. A nonzero dead_cnt decrements by 1 per cycle. With DEAD_CYCLES=4, the earliest next acceptance on the same channel is 5 cycles later.
- ts: held at 0 while activate=0, so it is cleared whenever activate falls. It increments by 1 per cycle while activate=1 and wraps from 2^TS_W-1 to 0. The cycle in which ts==0 immediately after a wrap is a rollover cycle.
- Event generation:
  - An event is pushed in any cycle with at least one accepted hit or a rollover cycle.
  - The event carries mask = accepted-hit vector, rollover flag, and timestamp = ts value in that cycle.
  - Simultaneous hits on several channels produce one event with multiple mask bits set.
  - A hit coinciding with a rollover produces one event with rollover=1 and a nonzero mask.
- Latency: when detectors first reads high at edge k, with ts=T before that edge, the event timestamp is T+2, it is written at edge k+2, and ev_valid is high from edge k+2 when the FIFO was empty.
- FIFO: show-ahead; ev_mask, ev_rollover and ev_timestamp reflect the head entry whenever ev_valid=1. Pop occurs on ev_valid & ev_ready. Outputs are stable while ev_valid & ~ev_ready. Order is strictly FIFO.
- Full: a push while full is accepted if a pop occurs in the same cycle. Otherwise the event is dropped, overflow<=1 and drop_count increments (saturating).
- Empty: ev_ready is ignored when ev_valid=0. Simultaneous push and pop on an empty FIFO is impossible because a new entry is only visible after its write edge.
- A rising edge of activate (0 to 1) clears overflow and drop_count but not FIFO contents. When activate=0, no new events are pushed and the FIFO continues to drain.

Test Plan:
- Reset 25 cycles, activate=1, 5-cycle pulse on detectors[0] when ts=100 before edge k -> exactly one event: mask=4'b0001, rollover=0, timestamp=102, ev_valid from edge k+2. ev_ready=1 -> ev_valid drops next cycle.
- detectors[1] and detectors[3] rise in the same cycle -> one event with mask=4'b1010. Pulses on detectors[2] 3 cycles apart (1-cycle wide, DEAD_CYCLES=4) -> second pulse dropped silently: overflow=0, one event only.
- TS_W=8, activate held 256+ cycles, no hits -> event mask=0, rollover=1, timestamp=0. A hit landing in that same cycle -> a single event with rollover=1 and mask nonzero.
- ev_ready=0, generate 20 hits with FIFO_DEPTH=16 -> 16 events queued, overflow=1, drop_count=4. Then ev_ready=1 -> 16 events drained in order with increasing timestamps. Toggling activate 0 to 1 clears drop_count to 0.
- Hold ev_ready=0 with ev_valid=1 for 10 cycles while new hits arrive -> head outputs unchanged. FIFO full with push and pop in the same cycle -> no drop.
- Assert reset with 5 events queued -> next cycle ev_valid=0 and drop_count=0, and ts stays 0 until activate is asserted.

Source files
------------

// File: rtl/detector_event_capture.sv
// rtl/detector_event_capture.sv - detector sync, dead-time edge capture, timestamped event FIFO
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   activate         capture enable; timestamp runs and hits are accepted only while high
//   detectors        asynchronous detector pulses, one bit per channel
//   ev_valid/ev_ready  show-ahead event handshake toward the serializer
//   ev_mask          channels hit in the head event's cycle
//   ev_rollover      head event marks a timestamp wrap
//   ev_timestamp     timestamp of the head event
//   overflow         sticky: at least one event was dropped on a full FIFO
//   drop_count       saturating count of dropped events
module detector_event_capture #(
    parameter int NCH         = 4,
    parameter int TS_W        = 32,
    parameter int DEAD_CYCLES = 4,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            activate,
    input  logic [NCH-1:0]  detectors,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [NCH-1:0]  ev_mask,
    output logic            ev_rollover,
    output logic [TS_W-1:0] ev_timestamp,
    output logic            overflow,
    output logic [15:0]     drop_count
);

    localparam int DW = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = NCH + 1 + TS_W;

    logic [NCH-1:0]  s1, s2, s3;
    logic [DW-1:0]   dead_cnt [NCH];
    logic [TS_W-1:0] ts;
    logic            wrap_q;
    logic            act_q;

    logic [NCH-1:0]  raw_hit;
    logic [NCH-1:0]  hit;
    logic            rollover;
    logic            push;
    logic            pop;
    logic            push_ok;
    logic            drop;
    logic            full;
    logic            empty;

    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic [EW-1:0]   head;

    // Two-flop synchronizer plus one history stage for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= detectors;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        raw_hit = s2 & ~s3;
        hit     = '0;
        for (int i = 0; i < NCH; i++) begin
            hit[i] = raw_hit[i] & activate & (dead_cnt[i] == '0);
        end
    end

    // Dead counters keep counting down even while capture is disabled.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                dead_cnt[i] <= '0;
            end else if (hit[i]) begin
                dead_cnt[i] <= DW'(DEAD_CYCLES);
            end else if (dead_cnt[i] != '0) begin
                dead_cnt[i] <= dead_cnt[i] - DW'(1);
            end
        end
    end

    // Timestamp is held at zero while inactive; wrap_q flags the cycle where
    // ts reads zero because it just wrapped, not because capture restarted.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts     <= '0;
            wrap_q <= 1'b0;
            act_q  <= 1'b0;
        end else begin
            ts     <= activate ? ts + TS_W'(1) : '0;
            wrap_q <= activate && (ts == '1);
            act_q  <= activate;
        end
    end

    assign rollover = wrap_q & activate;
    assign push     = activate & ((|hit) | rollover);

    // FIFO: pointers carry one extra bit to tell full from empty.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign ev_valid = ~empty;
    assign pop      = ev_valid & ev_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok  = push & (~full | pop);
    assign drop     = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= {hit, rollover, ts};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign head         = mem[rd_ptr[AW-1:0]];
    assign ev_mask      = ev_valid ? head[EW-1 -: NCH] : '0;
    assign ev_rollover  = ev_valid ? head[TS_W] : 1'b0;
    assign ev_timestamp = ev_valid ? head[TS_W-1:0] : '0;

    // A rising activate starts a fresh drop tally; a drop in that same
    // cycle is still counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (activate && !act_q) begin
            overflow   <= drop;
            drop_count <= drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule
